// File: rtl/reduction_ctrl.sv
// reduction_ctrl -- control sequencer for the per-tile FP16 reduction datapath.
//
// Takes a reduction command (beat count), seeds the accumulator from its
// preset, and admits operand beats no closer together than ADD_LAT cycles.
// This spacing means the adder tree never reads a stale accumulator value.
// It strobes the accumulator capture ADD_LAT-1 cycles after each issue. Once
// the last sum has landed it holds a result handshake until it is consumed.
// Only control strobes are driven; no data passes through this block.
//
// Parameters:
//   LEN_W         width of the beat-count field
//   ADD_LAT       operand issue -> accumulator capture latency (>= 1),
//                 which is also the minimum issue spacing
//   PARALLEL_SIZE operand slices per beat (informational, sizes nothing)
//
// Ports:
//   CLK_i, RST_i              clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake, cmd_len_i = beat count (0 ok)
//   op_valid_i/op_ready_o     operand beat handshake ("op fire")
//   acc_load_o                accumulator <= preset value (one cycle)
//   acc_en_o                  accumulator <= adder-tree output (one cycle)
//   res_valid_o/res_ready_i   result handshake
//   busy_o                    high whenever not IDLE
//   stall_cnt_o               only with REDUCTION_CTRL_PERF_EN defined. Counts
//                             ACCUM cycles that were ready but had no operand.
//                             Saturating, and cleared by each command's LOAD.
//
// Optional feature macro: REDUCTION_CTRL_PERF_EN
module reduction_ctrl #(
    parameter int LEN_W         = 16,
    parameter int ADD_LAT       = 3,
    parameter int PARALLEL_SIZE = 3
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    output logic             acc_load_o,
    output logic             acc_en_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o
`ifdef REDUCTION_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int GAP_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    if (ADD_LAT < 1 || PARALLEL_SIZE < 1) begin : g_bad_param
        $error("reduction_ctrl: ADD_LAT and PARALLEL_SIZE must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [GAP_W-1:0]   gap;
    logic               op_fire;
    logic               drain_done;

    assign op_fire = (state == ACCUM) && (gap == '0) && op_valid_i;
    assign busy_o  = (state != IDLE);

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state     <= IDLE;
            remaining <= '0;
            gap       <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && cmd_valid_i)
                remaining <= cmd_len_i;
            else if (op_fire && remaining != '0)
                remaining <= remaining - LEN_W'(1);

            // The gap counter enforces the issue spacing. It keeps counting
            // down outside ACCUM so that it is always zero again by DONE.
            if (op_fire)
                gap <= GAP_W'(ADD_LAT - 1);
            else if (gap != '0)
                gap <= gap - GAP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        op_ready_o  = 1'b0;
        acc_load_o  = 1'b0;
        res_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i)
                    state_nxt = LOAD;
            end
            LOAD: begin
                acc_load_o = 1'b1;
                state_nxt  = (remaining == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                op_ready_o = (gap == '0);
                // With ADD_LAT == 1 the last capture happens in the same
                // cycle as the last issue, so there is nothing to drain.
                if (op_fire && remaining == LEN_W'(1))
                    state_nxt = (ADD_LAT == 1) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (drain_done)
                    state_nxt = DONE;
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue tracking. A fire emerges as acc_en_o ADD_LAT-1 cycles later. The
    // fire itself is stage 0 and is taken combinationally, so only ADD_LAT-1
    // registered stages are needed.
    // ------------------------------------------------------------------
    if (ADD_LAT == 1) begin : g_lat1
        assign acc_en_o   = op_fire;
        assign drain_done = 1'b1;
    end else begin : g_pipe
        logic [ADD_LAT-2:0] vld_pipe;

        always_ff @(posedge CLK_i) begin
            if (RST_i) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= op_fire;
                for (int i = 1; i < ADD_LAT - 1; i++)
                    vld_pipe[i] <= vld_pipe[i-1];
            end
        end

        assign acc_en_o = vld_pipe[ADD_LAT-2];
        // Drain completes once nothing is left behind the stage that
        // is strobing now. DONE then follows right after the last acc_en_o.
        assign drain_done = ((vld_pipe << 1) == '0);
    end

`ifdef REDUCTION_CTRL_PERF_EN
    always_ff @(posedge CLK_i) begin
        if (RST_i)
            stall_cnt_o <= '0;
        else if (state == LOAD)
            stall_cnt_o <= '0;
        else if (state == ACCUM && op_ready_o && !op_valid_i && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_reduction_ctrl.sv
// Self-checking bench for reduction_ctrl. It has two instances, one with
// ADD_LAT=3 and one with ADD_LAT=1. The expected strobes come from a
// cycle-indexed model of the command. Its inputs are load at cycle 1, the
// earliest issue at cycle 2, issue spacing of at least ADD_LAT, capture
// ADD_LAT-1 cycles after each issue, and the result starting one cycle after
// the last capture.
module tb_reduction_ctrl;
    localparam int LEN_W = 16;
    localparam int LAT0  = 3;
    localparam int LAT1  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             cmd_valid [2];
    logic             cmd_ready [2];
    logic [LEN_W-1:0] cmd_len   [2];
    logic             op_valid  [2];
    logic             op_ready  [2];
    logic             acc_load  [2];
    logic             acc_en    [2];
    logic             res_valid [2];
    logic             res_ready [2];
    logic             busy      [2];
`ifdef REDUCTION_CTRL_PERF_EN
    logic [31:0]      stall_cnt [2];
`endif

    int tests = 0;
    int fails = 0;

    reduction_ctrl #(.LEN_W(LEN_W), .ADD_LAT(LAT0), .PARALLEL_SIZE(3)) u_dut0 (
        .CLK_i(clk), .RST_i(rst),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_len_i(cmd_len[0]),
        .op_valid_i(op_valid[0]), .op_ready_o(op_ready[0]),
        .acc_load_o(acc_load[0]), .acc_en_o(acc_en[0]),
        .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]), .busy_o(busy[0])
`ifdef REDUCTION_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt[0])
`endif
    );

    reduction_ctrl #(.LEN_W(LEN_W), .ADD_LAT(LAT1), .PARALLEL_SIZE(3)) u_dut1 (
        .CLK_i(clk), .RST_i(rst),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_len_i(cmd_len[1]),
        .op_valid_i(op_valid[1]), .op_ready_o(op_ready[1]),
        .acc_load_o(acc_load[1]), .acc_en_o(acc_en[1]),
        .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]), .busy_o(busy[1])
`ifdef REDUCTION_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt[1])
`endif
    );

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_len[d]   = '0;
            op_valid[d]  = 1'b0;
            res_ready[d] = 1'b0;
        end
    endtask

    // Output vector order: {cmd_ready, op_ready, acc_load, acc_en, res_valid, busy}
    task automatic test_reset();
        logic [5:0] got;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            got = {cmd_ready[d], op_ready[d], acc_load[d], acc_en[d], res_valid[d], busy[d]};
            tests++;
            if (got !== 6'b100000) begin
                fails++;
                $display("FAIL reset_state dut%0d got %b exp %b", d, got, 6'b100000);
            end
`ifdef REDUCTION_CTRL_PERF_EN
            tests++;
            if (stall_cnt[d] !== 32'd0) begin
                fails++;
                $display("FAIL reset_stall dut%0d got %0d exp 0", d, stall_cnt[d]);
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    // Runs one command on dut d, starting in IDLE at posedge+1.
    // vmode: 0 op_valid high, 1 random, 2 withhold for 7 ready cycles then
    // offer. hold: cycles res_ready is kept low in DONE. keep_cmd: keep
    // cmd_valid high throughout, with junk lengths after cycle 0.
    task automatic run_cmd(input int d, input int len, input int vmode,
                           input int hold, input bit keep_cmd);
        int L, k, fires, last_fire, stalls, dcnt, run7;
        int fire_q[$];
        bit hs, in_done, e_oready, e_en, fire, ov, rr;
        logic [5:0] got, exp;
        L = (d == 0) ? LAT0 : LAT1;
        k = 0; fires = 0; last_fire = -1000; stalls = 0; dcnt = 0; run7 = 0; hs = 0;
        fire_q.delete();
        while (!hs && k < 4000) begin
            e_oready = (k >= 2) && (fires < len) && (k - last_fire >= L);
            in_done  = (k >= 2) && (fires == len) && (len == 0 || k >= last_fire + L);
            case (vmode)
                0:       ov = 1'b1;
                1:       ov = 1'($urandom_range(0, 1));
                default: ov = (run7 >= 7);
            endcase
            rr = in_done ? (dcnt >= hold) : 1'($urandom_range(0, 1));
            cmd_valid[d] = (k == 0) || keep_cmd;
            cmd_len[d]   = (k == 0) ? LEN_W'(len) : LEN_W'($urandom);
            op_valid[d]  = ov;
            res_ready[d] = rr;
            fire = e_oready && ov;
            if (fire) fire_q.push_back(k);
            e_en = 1'b0;
            foreach (fire_q[i]) if (fire_q[i] == k - L + 1) e_en = 1'b1;
            exp = {k == 0, e_oready, k == 1, e_en, in_done, k >= 1};
            @(negedge clk);
            got = {cmd_ready[d], op_ready[d], acc_load[d], acc_en[d], res_valid[d], busy[d]};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL ctrl dut%0d len=%0d k=%0d got %b exp %b", d, len, k, got, exp);
            end
`ifdef REDUCTION_CTRL_PERF_EN
            if (in_done) begin
                tests++;
                if (stall_cnt[d] !== 32'(stalls)) begin
                    fails++;
                    $display("FAIL stall_cnt dut%0d k=%0d got %0d exp %0d", d, k, stall_cnt[d], stalls);
                end
            end
`endif
            @(posedge clk); #1;
            if (fire) begin
                fires++; last_fire = k; run7 = 0;
            end else if (e_oready && !ov) begin
                run7++; stalls++;
            end
            if (in_done) begin
                if (rr) hs = 1'b1;
                else dcnt++;
            end
            k++;
        end
        if (!hs) begin
            tests++; fails++;
            $display("FAIL timeout dut%0d len=%0d got no handshake exp handshake", d, len);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        run_cmd(0, 4, 0, 0, 0);   // issues 2,5,8,11; captures 4,7,10,13; result 14
        run_cmd(0, 0, 0, 0, 0);   // zero-length: load 1, result 2
        run_cmd(1, 0, 0, 1, 0);
        run_cmd(1, 3, 0, 0, 0);   // ADD_LAT=1: issue+capture 2,3,4; result 5
        run_cmd(0, 1, 0, 2, 0);
    endtask

    task automatic test_back_to_back();
        run_cmd(0, 2, 0, 5, 1);   // result held 5 cycles, cmd_valid held high
        run_cmd(0, 3, 0, 0, 1);   // accepted the cycle after the handshake
        run_cmd(1, 2, 0, 5, 1);
        run_cmd(1, 1, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_cmd(n % 2, int'($urandom_range(0, 7)), 1, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_stall();
        run_cmd(1, 2, 2, 0, 0);   // 7 idle ready cycles before each beat: 14 stalls
        run_cmd(0, 2, 2, 1, 0);
    endtask

    task automatic test_reset_mid();
        logic [1:0] got, exp;
        cmd_valid[0] = 1'b1;
        cmd_len[0]   = LEN_W'(4);
        op_valid[0]  = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k == 1) cmd_valid[0] = 1'b0;
            if (k == 6) rst = 1'b1;       // one cycle after the second issue (k=5)
            exp = {k == 2 || k == 5, k == 4};
            @(negedge clk);
            got = {op_ready[0], acc_en[0]};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL pre_reset k=%0d got %b exp %b", k, got, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            got = {acc_en[0], busy[0]};
            tests++;
            if (got !== 2'b00 || cmd_ready[0] !== 1'b1) begin
                fails++;
                $display("FAIL post_reset k=%0d got en/busy=%b rdy=%b exp 00/1", k, got, cmd_ready[0]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_mid();
        run_cmd(0, 3, 1, 1, 0);   // normal operation resumes after the abort
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
